// File: rtl/boot_loader.sv
// Boot-stream loader: takes a 16-bit big-endian word count followed by the image bytes,
// writes big-endian words to memory, then releases the CPU from reset.
module boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Handshake: a byte moves on a rising edge only when in_valid and in_ready are both 1.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam logic [31:0]   CAP     = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = 1;

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         n_q, n_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         word_q, word_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic [15:0]         n_new;
    logic                xfer;

    assign in_ready  = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
    assign xfer      = in_valid && in_ready;
    assign n_new     = {len_hi_q, in_data};
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign done      = (state_q == DONE);
    assign cpu_reset = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            len_hi_q   <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        n_d        = n_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        word_d     = word_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            IDLE: state_d = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    n_d = n_new;
                    if (n_new == 16'd0) begin
                        state_d = DONE;
                    end else if ({16'd0, n_new} > CAP) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                        lane_d  = 2'd0;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    lane_d = lane_q + 2'd1;
                    word_d = {word_q[15:0], in_data};
                    if (lane_q == 2'd3) begin
                        // The write is registered, so it appears the cycle after the lane-3 byte.
                        mem_we_d   = 1'b1;
                        mem_addr_d = idx_q[ADDR_W-1:0];
                        mem_din_d  = {word_q, in_data};
                        idx_d      = idx_q + IDX_ONE;
                        if (32'(idx_q) + 32'd1 == {16'd0, n_q}) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 10: word-address width of the target memory; capacity is 2^ADDR_W words.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting it (0) immediately forces the reset state.
REQ-004 in_valid  input  1  the byte on in_data is valid.
REQ-005 in_data  input  8  boot-stream byte.
REQ-006 in_ready  output  1  loader can accept a byte this cycle.
REQ-007 mem_we  output  1  write strobe to the instruction/data memory port.
REQ-008 mem_addr  output  ADDR_W  word address for the memory write.
REQ-009 mem_din  output  32  word data for the memory write.
REQ-010 cpu_reset  output  1  active-low reset to the CPU; 0 holds the CPU in reset.
REQ-011 done  output  1  image fully loaded.
REQ-012 err  output  1  image length exceeds memory capacity.

Function
REQ-013 A byte transfers only on a rising edge where in_valid=1 and in_ready=1; no other condition transfers a byte.
REQ-014 States: IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERR.
REQ-015 IDLE goes unconditionally to LEN_HI one cycle after reset deassertion, with in_ready=0 in IDLE.
REQ-016 in_ready is 1 exactly in LEN_HI, LEN_LO and DATA, and 0 in every other state.
REQ-017 Stream format: 16-bit word count N, big-endian (LEN_HI byte = N[15:8], LEN_LO byte = N[7:0]), followed by 4*N data bytes.
REQ-018 LEN_HI goes to LEN_LO on a transfer.
REQ-019 LEN_LO transfer routing: N=0 goes to DONE; N>2^ADDR_W goes to ERR; otherwise it goes to DATA with the word index cleared to 0 and the byte lane cleared to 0.
REQ-020 DATA words are big-endian: lanes 0, 1, 2, 3 fill bits [31:24], [23:16], [15:8], [7:0] in that order.
REQ-021 Idle cycles (in_valid=0) between any bytes are permitted and leave all state unchanged.
REQ-022 On the transfer of lane 3, the following cycle has mem_we=1 for exactly one cycle, mem_addr=current word index, and mem_din=the assembled word.
REQ-023 The word index increments after each word write; a further byte may be accepted in the same cycle as mem_we=1, so there is no stall.
REQ-024 mem_addr and mem_din hold their last values when mem_we=0.
REQ-025 When the lane-3 transfer completes word N-1, DATA goes to FLUSH; FLUSH issues the final mem_we cycle and then goes to DONE.
REQ-026 DONE: done=1 and cpu_reset=1, both first asserted in the cycle after the final mem_we cycle; DONE is held until reset.
REQ-027 ERR: err=1, cpu_reset=0 and no memory writes; ERR is held until reset.
REQ-028 In DONE and ERR, in_valid is ignored and no memory write occurs.
REQ-029 The word index is ADDR_W+1 bits wide so that N=2^ADDR_W is legal, and mem_addr never wraps.
REQ-030 cpu_reset is 0 in every state except DONE.

Reset
REQ-031 While reset=0, all outputs are 0: in_ready, mem_we, mem_addr, mem_din, cpu_reset, done, err; the state is IDLE and the lane and word counters are 0.
REQ-032 Reset asserted mid-load aborts the load immediately, leaves partially written words unreverted, and restarts at IDLE on release.

Verification
REQ-033 Stream 00 02 | 12 34 56 78 | 9A BC DE F0, back-to-back -> mem_we pulses at addr 0 with data 0x12345678 and at addr 1 with data 0x9ABCDEF0; done=1 and cpu_reset=1 the cycle after the second pulse.
REQ-034 Stream 00 00 -> no mem_we; done=1 and cpu_reset=1 the cycle after the LEN_LO transfer; further in_valid bytes are not accepted (in_ready=0).
REQ-035 ADDR_W=10, stream 04 01 -> err=1, cpu_reset stays 0, no mem_we; stream 04 00 followed by 4096 bytes -> last write at addr 1023, then done=1.
REQ-036 One-word load with in_valid deasserted for 3 cycles between every byte -> identical memory write and done timing relative to the last byte accepted.
REQ-037 Assert reset after 6 data bytes of an N=2 load, then reload 00 01 AA BB CC DD -> all outputs 0 during reset; single write at addr 0 with data 0xAABBCCDD; done=1.
